mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter: data_width, 32, width of each requester data word and of o_data.
REQ-002 Parameter: timeout, 16, max cycles o_valid may stall waiting for i_ready; 0 disables the timeout.
REQ-003 Port: i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: i_req  input  4  per-requester request; bit k belongs to requester k.
REQ-006 Port: i_a, i_b, i_c, i_d  input  data_width each  data of requesters 0..3.
REQ-007 Port: i_ready  input  1  downstream accepts o_data this cycle.
REQ-008 Port: o_sel  output  2  index of current owner; drives the 4:1 datapath mux select.
REQ-009 Port: o_data  output  data_width  captured data of the winning requester.
REQ-010 Port: o_valid  output  1  o_data holds an unaccepted transfer.
REQ-011 Port: o_ack  output  4  one-hot, one-cycle pulse telling requester k its data was captured.
REQ-012 Port: o_timeout  output  1  one-cycle pulse when a transfer is dropped on timeout.

Function
REQ-013 FSM SHALL have two states: IDLE (o_valid=0) and HOLD (o_valid=1).
REQ-014 IDLE with i_req==0: SHALL stay IDLE; all outputs hold; o_ack=0.
REQ-015 IDLE with i_req!=0: SHALL pick winner k as first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4), then at the edge register o_sel=k, o_data=selected input (a/b/c/d for k=0/1/2/3), o_valid=1, and enter HOLD.
REQ-016 o_ack[k] SHALL be 1 for exactly the first HOLD cycle after capture; 0 otherwise.
REQ-017 Latency: request sampled in IDLE cycle N -> o_valid and o_ack high in cycle N+1.
REQ-018 In HOLD, o_sel, o_data and o_valid SHALL stay stable until transfer ends; i_req and requester data are ignored.
REQ-019 HOLD with i_ready=1: transfer completes; next cycle SHALL be IDLE with o_valid=0; ptr SHALL become (k+1) mod 4.
REQ-020 At least one IDLE cycle SHALL separate consecutive captures (max throughput one transfer per 2 cycles), giving requesters a cycle to drop i_req after o_ack.
REQ-021 Stall counter SHALL count HOLD cycles with i_ready=0 and clear on entry to HOLD.
REQ-022 timeout!=0 and o_valid high for timeout consecutive cycles with i_ready=0: SHALL go IDLE next cycle, o_valid=0, o_timeout=1 for one cycle, ptr=(k+1) mod 4.
REQ-023 i_ready=1 in the cycle the timeout would fire: transfer SHALL complete normally; o_timeout stays 0.
REQ-024 timeout=0: HOLD SHALL persist indefinitely until i_ready=1.
REQ-025 o_sel and o_data SHALL retain their last values in IDLE; only o_valid qualifies them.

Reset
REQ-026 i_rst_n low SHALL immediately, regardless of clock, force state=IDLE, ptr=0, stall counter=0, o_sel=0, o_data=0, o_valid=0, o_ack=0, o_timeout=0.
REQ-027 Reset during HOLD SHALL discard the pending transfer with no o_timeout pulse; first capture after release uses ptr=0.
REQ-028 First capture SHALL occur no earlier than the first rising edge after i_rst_n deasserts.

Verification
REQ-029 After reset, i_req=4'b1111, i_ready=1 constant -> grants in order 0,1,2,3,0, one per 2 cycles; o_ack = 0001, 0010, 0100, 1000, 0001.
REQ-030 i_req=4'b0100 at cycle N, i_c=32'hDEADBEEF -> cycle N+1: o_sel=2, o_data=32'hDEADBEEF, o_valid=1, o_ack=4'b0100.
REQ-031 Capture of requester 1, i_ready=0 for 5 cycles, i_b changed meanwhile -> o_data/o_sel unchanged; accepted on cycle i_ready=1; next capture starts scan at requester 2.
REQ-032 timeout=4, i_ready held 0 -> o_valid high exactly 4 cycles, then o_valid=0 with o_timeout=1 for one cycle; i_ready=1 on the 4th cycle instead -> no o_timeout.
REQ-033 i_rst_n pulsed low mid-HOLD (between clock edges) -> o_valid=0 and o_sel=0 immediately; after release, i_req=4'b1010 grants requester 1 first.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: four-way round-robin arbiter that captures the winner's data word and holds it until it is accepted or times out.
module mux4_rr_arbiter #(
    parameter int data_width = 32,
    parameter int timeout    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [3:0]            i_req,
    input  logic [data_width-1:0] i_a,
    input  logic [data_width-1:0] i_b,
    input  logic [data_width-1:0] i_c,
    input  logic [data_width-1:0] i_d,
    input  logic                  i_ready,
    output logic [1:0]            o_sel,
    output logic [data_width-1:0] o_data,
    output logic                  o_valid,
    output logic [3:0]            o_ack,
    output logic                  o_timeout
);
    localparam int cw = (timeout > 1) ? $clog2(timeout) : 1;
    localparam logic [cw-1:0] stall_max = cw'((timeout > 0) ? timeout - 1 : 0);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                  state, state_nxt;
    logic [1:0]              ptr, win, ofs;
    logic [7:0]              req2;
    logic [3:0]              rot;
    logic [cw-1:0]           stall;
    logic [data_width-1:0]   sel_data;
    logic                    capture, done, expire;

    // Rotating the request vector by ptr turns the round-robin scan into a fixed-priority one.
    always_comb begin
        req2      = {i_req, i_req};
        rot       = req2[ptr +: 4];
        ofs       = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        win       = ptr + ofs;
        sel_data  = (win == 2'd0) ? i_a : (win == 2'd1) ? i_b : (win == 2'd2) ? i_c : i_d;
        expire    = (timeout != 0) && !i_ready && (stall == stall_max);
        capture   = (state == IDLE) && (i_req != 4'd0);
        done      = (state == HOLD) && (i_ready || expire);
        state_nxt = capture ? HOLD : done ? IDLE : state;
    end

    assign o_valid = (state == HOLD);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            stall     <= '0;
            o_sel     <= 2'd0;
            o_data    <= '0;
            o_ack     <= 4'd0;
            o_timeout <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_ack     <= capture ? (4'b0001 << win) : 4'd0;
            o_timeout <= (state == HOLD) && expire;
            if (capture) begin
                o_sel  <= win;
                o_data <= sel_data;
                stall  <= '0;
            end else if (state == HOLD && !i_ready) begin
                stall <= stall + 1'b1;
            end
            if (done)
                ptr <= o_sel + 2'd1;
        end
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: scoreboard bench; expected captures are queued at drive time and popped on each o_ack pulse.
module tb_mux4_rr_arbiter;
    localparam int dw        = 32;
    localparam int to_cycles = 8;

    typedef struct packed {
        logic [1:0]    sel;
        logic [dw-1:0] data;
        logic [3:0]    ack;
    } exp_t;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [3:0]    i_req = 4'd0;
    logic [dw-1:0] i_a = '0, i_b = '0, i_c = '0, i_d = '0;
    logic          i_ready = 1'b0;
    logic [1:0]    o_sel;
    logic [dw-1:0] o_data;
    logic          o_valid;
    logic [3:0]    o_ack;
    logic          o_timeout;

    exp_t       exp_q[$];
    int         checks = 0;
    int         fails = 0;
    int         acks = 0;
    logic [1:0] ptr_m = 2'd0;

    mux4_rr_arbiter #(.data_width(dw), .timeout(to_cycles)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req),
        .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_d(i_d), .i_ready(i_ready),
        .o_sel(o_sel), .o_data(o_data), .o_valid(o_valid),
        .o_ack(o_ack), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] p);
        pick = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (req[(int'(p) + i) % 4]) pick = 2'((int'(p) + i) % 4);
    endfunction

    function automatic logic [dw-1:0] data_of(input logic [1:0] k);
        case (k)
            2'd0:    data_of = i_a;
            2'd1:    data_of = i_b;
            2'd2:    data_of = i_c;
            default: data_of = i_d;
        endcase
    endfunction

    task automatic expect_cap(output logic [1:0] w);
        exp_t e;
        w = pick(i_req, ptr_m);
        e.sel = w;
        e.data = data_of(w);
        e.ack = 4'b0001 << w;
        exp_q.push_back(e);
    endtask

    always @(negedge i_clk) begin
        if (i_rst_n && o_ack != 4'd0) begin
            acks++;
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 64'(o_ack), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("cap_sel", 64'(o_sel), 64'(e.sel));
                check("cap_data", 64'(o_data), 64'(e.data));
                check("cap_ack", 64'(o_ack), 64'(e.ack));
                check("cap_valid", 64'(o_valid), 64'd1);
            end
        end
    end

    // Starts from IDLE at posedge+1; stalls for 'stall' cycles while scrambling inputs, then accepts.
    task automatic transfer(input logic [3:0] req, input int stall);
        logic [1:0]    w;
        logic [dw-1:0] d;
        i_req = req;
        i_ready = 1'b0;
        expect_cap(w);
        d = data_of(w);
        @(posedge i_clk); #1;
        i_req = 4'd0;
        check("hold_valid", 64'(o_valid), 64'd1);
        for (int n = 0; n < stall; n++) begin
            i_a = ~i_a; i_b = ~i_b; i_c = ~i_c; i_d = ~i_d;
            i_req = 4'hf;
            @(posedge i_clk); #1;
            check("hold_sel", 64'(o_sel), 64'(w));
            check("hold_data", 64'(o_data), 64'(d));
        end
        i_req = 4'd0;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        check("done_valid", 64'(o_valid), 64'd0);
        check("done_no_timeout", 64'(o_timeout), 64'd0);
        check("idle_sel_kept", 64'(o_sel), 64'(w));
        ptr_m = w + 2'd1;
    endtask

    task automatic expire_run(input logic [3:0] req);
        logic [1:0] w;
        int n;
        i_req = req;
        i_ready = 1'b0;
        expect_cap(w);
        @(posedge i_clk); #1;
        i_req = 4'd0;
        n = 0;
        for (int c = 0; c < 5 * to_cycles && o_valid; c++) begin
            n++;
            @(posedge i_clk); #1;
        end
        check("to_valid_cycles", 64'(n), 64'(to_cycles));
        check("to_pulse", 64'(o_timeout), 64'd1);
        @(posedge i_clk); #1;
        check("to_pulse_len", 64'(o_timeout), 64'd0);
        ptr_m = w + 2'd1;
    endtask

    initial begin
        logic [1:0] w;
        int a0;
        #2;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_sel", 64'(o_sel), 64'd0);
        check("rst_data", 64'(o_data), 64'd0);
        check("rst_ack", 64'(o_ack), 64'd0);
        check("rst_timeout", 64'(o_timeout), 64'd0);
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("idle_valid", 64'(o_valid), 64'd0);
        check("idle_ack", 64'(o_ack), 64'd0);

        i_a = $urandom; i_b = $urandom; i_c = 32'hDEADBEEF; i_d = $urandom;
        transfer(4'b0100, 0);
        transfer(4'b0010, 5);
        transfer(4'b1111, 0);
        i_a = $urandom; i_b = $urandom; i_c = $urandom; i_d = $urandom;
        transfer(4'b1001, 2);
        transfer(4'b0110, to_cycles - 1);

        @(posedge i_clk); #1 i_rst_n = 1'b0;
        #2 i_rst_n = 1'b1;
        ptr_m = 2'd0;
        a0 = acks;
        i_req = 4'hf;
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_cap(w);
            ptr_m = w + 2'd1;
        end
        repeat (9) @(posedge i_clk);
        #1 i_req = 4'd0;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        check("burst_acks", 64'(acks - a0), 64'd5);
        check("burst_valid", 64'(o_valid), 64'd0);

        expire_run(4'b0001);
        expire_run(4'b1100);
        transfer(4'b1111, 1);

        i_req = 4'b1000;
        expect_cap(w);
        @(posedge i_clk); #1;
        i_req = 4'd0;
        @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(o_valid), 64'd0);
        check("async_rst_sel", 64'(o_sel), 64'd0);
        check("async_rst_data", 64'(o_data), 64'd0);
        #1 i_rst_n = 1'b1;
        ptr_m = 2'd0;
        @(posedge i_clk); #1;
        check("rst_no_timeout", 64'(o_timeout), 64'd0);
        check("rst_idle", 64'(o_valid), 64'd0);
        transfer(4'b1010, 0);

        repeat (3) @(posedge i_clk);
        #1;
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
